// File: rtl/dpd_mag_addr_gen.sv
// Converts a pair of complex baseband samples per clock into DPD LUT magnitude
// addresses via abs, sort, alpha-max-beta-min estimate, gain and quantisation.
module dpd_mag_addr_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din_odd,
    input  logic [DATA_WIDTH-1:0] din_even,
    input  logic [GAIN_WIDTH-1:0] gain,
    output logic [ADDR_WIDTH-1:0] mag_odd,
    output logic [ADDR_WIDTH-1:0] mag_even,
    output logic                  dout_valid,
    input  logic                  clip_cnt_clr,
    output logic [15:0]           clip_cnt
);

    // Lane 0 is the odd (earlier) sample, lane 1 the even one; never swap them.
    logic [DATA_WIDTH-1:0] lane_din [2];

    logic [14:0]           abs_i_q [2], abs_i_d [2];
    logic [14:0]           abs_q_q [2], abs_q_d [2];
    logic [14:0]           mx_q    [2], mx_d    [2];
    logic [14:0]           mn_q    [2], mn_d    [2];
    logic [15:0]           est_q   [2], est_d   [2];
    logic                  ovf_q   [2], ovf_d   [2];
    logic [ADDR_WIDTH-1:0] sc_q    [2], sc_d    [2];
    logic [ADDR_WIDTH-1:0] addr_q  [2], addr_d  [2];
    logic                  clip_q  [2], clip_d  [2];
    logic [ADDR_WIDTH-1:0] mag_q   [2], mag_d   [2];
    logic                  clip_out_q [2], clip_out_d [2];

    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d, v5_q, v5_d;
    logic        dout_valid_q, dout_valid_d;
    logic [15:0] clip_cnt_q, clip_cnt_d;
    logic [1:0]  clip_inc;
    logic [16:0] clip_sum;

    assign lane_din[0] = din_odd;
    assign lane_din[1] = din_even;

    // -32768 has no 15-bit magnitude, so it saturates to full scale.
    function automatic logic [14:0] sat_abs(input logic [15:0] x);
        logic [14:0] r;
        if (!x[15])
            r = x[14:0];
        else if (x == 16'h8000)
            r = 15'h7fff;
        else
            r = 15'(-x);
        return r;
    endfunction

    always_comb begin
        v1_d = din_valid;
        v2_d = v1_q;
        v3_d = v2_q;
        v4_d = v3_q;
        v5_d = v4_q;
        dout_valid_d = v5_q;
        for (int k = 0; k < 2; k++) begin
            abs_i_d[k] = sat_abs(lane_din[k][31:16]);
            abs_q_d[k] = sat_abs(lane_din[k][15:0]);
            mx_d[k]    = (abs_i_q[k] >= abs_q_q[k]) ? abs_i_q[k] : abs_q_q[k];
            mn_d[k]    = (abs_i_q[k] >= abs_q_q[k]) ? abs_q_q[k] : abs_i_q[k];
            est_d[k]   = {1'b0, mx_q[k]} + 16'(mn_q[k] >> 2) + 16'(mn_q[k] >> 3);
            // Only the overflow bits and the address slice of est*gain >> 14 are kept.
            ovf_d[k]   = |(2'((32'(est_q[k]) * 32'(gain)) >> 30));
            sc_d[k]    = ADDR_WIDTH'((32'(est_q[k]) * 32'(gain)) >> (30 - ADDR_WIDTH));
            addr_d[k]  = ovf_q[k] ? {ADDR_WIDTH{1'b1}} : sc_q[k];
            clip_d[k]  = ovf_q[k];
            mag_d[k]   = v5_q ? addr_q[k] : mag_q[k];
            clip_out_d[k] = v5_q & clip_q[k];
        end
    end

    always_comb begin
        clip_inc   = {1'b0, clip_out_q[0]} + {1'b0, clip_out_q[1]};
        clip_sum   = {1'b0, clip_cnt_q} + {15'd0, clip_inc};
        clip_cnt_d = clip_sum[16] ? 16'hffff : clip_sum[15:0];
        if (clip_cnt_clr)
            clip_cnt_d = 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            v5_q <= 1'b0;
            dout_valid_q <= 1'b0;
            clip_cnt_q   <= 16'd0;
            for (int k = 0; k < 2; k++) begin
                abs_i_q[k]    <= '0;
                abs_q_q[k]    <= '0;
                mx_q[k]       <= '0;
                mn_q[k]       <= '0;
                est_q[k]      <= '0;
                ovf_q[k]      <= 1'b0;
                sc_q[k]       <= '0;
                addr_q[k]     <= '0;
                clip_q[k]     <= 1'b0;
                mag_q[k]      <= '0;
                clip_out_q[k] <= 1'b0;
            end
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            v4_q <= v4_d;
            v5_q <= v5_d;
            dout_valid_q <= dout_valid_d;
            clip_cnt_q   <= clip_cnt_d;
            for (int k = 0; k < 2; k++) begin
                abs_i_q[k]    <= abs_i_d[k];
                abs_q_q[k]    <= abs_q_d[k];
                mx_q[k]       <= mx_d[k];
                mn_q[k]       <= mn_d[k];
                est_q[k]      <= est_d[k];
                ovf_q[k]      <= ovf_d[k];
                sc_q[k]       <= sc_d[k];
                addr_q[k]     <= addr_d[k];
                clip_q[k]     <= clip_d[k];
                mag_q[k]      <= mag_d[k];
                clip_out_q[k] <= clip_out_d[k];
            end
        end
    end

    assign mag_odd    = mag_q[0];
    assign mag_even   = mag_q[1];
    assign dout_valid = dout_valid_q;
    assign clip_cnt   = clip_cnt_q;

endmodule

// File: tb/tb_dpd_mag_addr_gen.sv
// Scoreboard bench for dpd_mag_addr_gen: a behavioural lane model predicts
// addresses and clip counts; results are compared when outputs emerge.
module tb_dpd_mag_addr_gen;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din_valid;
    logic [31:0]   din_odd;
    logic [31:0]   din_even;
    logic [15:0]   gain;
    logic [AW-1:0] mag_odd;
    logic [AW-1:0] mag_even;
    logic          dout_valid;
    logic          clip_cnt_clr;
    logic [15:0]   clip_cnt;

    always #5 clk = ~clk;

    dpd_mag_addr_gen #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(AW),
        .GAIN_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din_valid(din_valid),
        .din_odd(din_odd),
        .din_even(din_even),
        .gain(gain),
        .mag_odd(mag_odd),
        .mag_even(mag_even),
        .dout_valid(dout_valid),
        .clip_cnt_clr(clip_cnt_clr),
        .clip_cnt(clip_cnt)
    );

    typedef struct {
        logic [AW-1:0] a_odd;
        logic [AW-1:0] a_even;
        int            clips;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [5:0]    vhist = '0;
    int            model_cnt = 0;
    int            pend = 0;
    logic [AW-1:0] last_odd = '0;
    logic [AW-1:0] last_even = '0;

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Straight arithmetic reading of the magnitude path for one sample.
    function automatic void laneModel(input logic [31:0] s, input logic [15:0] g,
                                      output logic [AW-1:0] a, output int clip);
        int     i, q, ai, aq, mx, mn, est;
        longint scaled;
        i  = int'($signed(s[31:16]));
        q  = int'($signed(s[15:0]));
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        est = mx + mn / 4 + mn / 8;
        scaled = (longint'(est) * longint'(g)) / 16384;
        clip = (scaled >= 65536) ? 1 : 0;
        a = (clip != 0) ? {AW{1'b1}} : AW'(scaled >> (16 - AW));
    endfunction

    // One clock: drive at the falling edge, update the models on the rising
    // edge, then compare outputs at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] o,
                                 input logic [31:0] e, input logic clr);
        exp_t          x;
        logic [AW-1:0] ao, ae;
        int            co, ce, nxt;
        din_valid    = v;
        din_odd      = o;
        din_even     = e;
        clip_cnt_clr = clr;
        if (v) begin
            laneModel(o, gain, ao, co);
            laneModel(e, gain, ae, ce);
            x.a_odd  = ao;
            x.a_even = ae;
            x.clips  = co + ce;
            sb.push_back(x);
        end
        @(posedge clk);
        vhist = {vhist[4:0], v};
        nxt = model_cnt + pend;
        model_cnt = clr ? 0 : ((nxt > 65535) ? 65535 : nxt);
        @(negedge clk);
        pend = 0;
        checkOutput("dout_valid", longint'(dout_valid), longint'(vhist[5]));
        if (vhist[5]) begin
            if (sb.size() == 0) begin
                checkOutput("scoreboard_underflow", 0, 1);
            end else begin
                x = sb.pop_front();
                last_odd  = x.a_odd;
                last_even = x.a_even;
                pend      = x.clips;
            end
        end
        checkOutput("mag_odd", longint'(mag_odd), longint'(last_odd));
        checkOutput("mag_even", longint'(mag_even), longint'(last_even));
        checkOutput("clip_cnt", longint'(clip_cnt), longint'(model_cnt));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic midReset();
        #2 rst_n = 1'b0;
        din_valid    = 1'b0;
        clip_cnt_clr = 1'b0;
        #1;
        checkOutput("rst_mag_odd", longint'(mag_odd), 0);
        checkOutput("rst_mag_even", longint'(mag_even), 0);
        checkOutput("rst_dout_valid", longint'(dout_valid), 0);
        checkOutput("rst_clip_cnt", longint'(clip_cnt), 0);
        sb.delete();
        vhist = '0;
        model_cnt = 0;
        pend = 0;
        last_odd = '0;
        last_even = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] FULL = {16'h7fff, 16'h7fff};

    initial begin
        rst_n        = 1'b0;
        din_valid    = 1'b0;
        din_odd      = '0;
        din_even     = '0;
        gain         = 16'h4000;
        clip_cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("reset_mag_odd", longint'(mag_odd), 0);
        checkOutput("reset_mag_even", longint'(mag_even), 0);
        checkOutput("reset_dout_valid", longint'(dout_valid), 0);
        checkOutput("reset_clip_cnt", longint'(clip_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] nominal pair");
        applyStimulus(1'b1, {16'd3000, 16'd4000}, {-16'sd4000, -16'sd3000}, 1'b0);
        idle(7);

        $display("[TB] abs boundary");
        applyStimulus(1'b1, {16'h8000, 16'h0000}, {16'h0000, 16'h8000}, 1'b0);
        idle(7);
        gain = 16'h8000;
        applyStimulus(1'b1, {16'h8000, 16'h0000}, {16'h0000, 16'h8000}, 1'b0);
        idle(7);

        $display("[TB] clip");
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, FULL, FULL, 1'b0);
        idle(8);

        $display("[TB] valid bubbles");
        gain = 16'h4000;
        applyStimulus(1'b1, {16'd1000, 16'd200}, {16'd2000, -16'sd500}, 1'b0);
        applyStimulus(1'b0, {16'd9000, 16'd9000}, {16'd9000, 16'd9000}, 1'b0);
        applyStimulus(1'b0, {16'd7000, 16'd100}, {16'd100, 16'd7000}, 1'b0);
        applyStimulus(1'b1, {-16'sd20000, 16'd12000}, {16'd30000, -16'sd30000}, 1'b0);
        idle(7);

        $display("[TB] random traffic");
        for (int g = 0; g < 4; g++) begin
            gain = 16'($urandom_range(0, 65535));
            for (int c = 0; c < 60; c++)
                applyStimulus(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                              ($urandom_range(0, 15) == 0));
            idle(7);
        end

        $display("[TB] clear priority");
        gain = 16'h8000;
        for (int c = 0; c < 12; c++) applyStimulus(1'b1, FULL, FULL, (c == 8));
        idle(8);

        $display("[TB] reset mid-stream");
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, FULL, {16'd5000, 16'd100}, 1'b0);
        midReset();
        idle(4);
        gain = 16'h4000;
        applyStimulus(1'b1, {16'd3000, 16'd4000}, {16'd8000, 16'd0}, 1'b0);
        idle(7);

        $display("[TB] counter saturation");
        gain = 16'h8000;
        for (int c = 0; c < 32800; c++) applyStimulus(1'b1, FULL, FULL, 1'b0);
        idle(8);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        idle(2);

        checkOutput("scoreboard_drained", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpd_mag_addr_gen.md
# dpd_mag_addr_gen

Upstream stage of the DPD actuator LUT rows. It converts two complex baseband samples per clock into the `mag_odd` and `mag_even` LUT addresses that drive every `dpd_luts_row_v2` instance. Each lane runs a five-stage pipeline: absolute value, max/min sort, alpha-max-beta-min magnitude estimate, programmable gain, and quantisation with saturation. A saturating clip counter is exposed for the configuration interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one complex sample, packed {I[15:0], Q[15:0]}, two's complement. Fixed at 32.
- `ADDR_WIDTH`, 10: LUT address width. Range 4..16.
- `GAIN_WIDTH`, 16: unsigned gain width, format Q2.14. Fixed at 16.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `din_valid`, in, 1: both `din_odd` and `din_even` carry valid samples this cycle.
- `din_odd`, in, `DATA_WIDTH`: earlier sample of the pair (samples 0, 2, 4, …).
- `din_even`, in, `DATA_WIDTH`: later sample of the pair (samples 1, 3, 5, …).
- `gain`, in, `GAIN_WIDTH`: magnitude gain. 0x4000 = 1.0.
- `mag_odd`, out, `ADDR_WIDTH`: LUT address for the odd lane.
- `mag_even`, out, `ADDR_WIDTH`: LUT address for the even lane.
- `dout_valid`, out, 1: `din_valid` delayed to align with the mag outputs.
- `clip_cnt_clr`, in, 1: synchronous clear of `clip_cnt`.
- `clip_cnt`, out, 16: saturating count of clipped addresses.

## Operation
The two lanes are identical and independent. Stage registers advance every clock. There is no backpressure. The valid bit travels with the data.

- S1 (abs): `|I|` and `|Q|`, 15-bit unsigned. -32768 saturates to 32767.
- S2 (sort): `mx` = max(`|I|`, `|Q|`), `mn` = min(`|I|`, `|Q|`). A tie gives `mx` = `mn`.
- S3 (estimate): `est` = `mx` + (`mn` >> 2) + (`mn` >> 3). Width is 16 bits unsigned, no overflow (maximum 45053).
  - Each shift truncates independently.
- S4 (gain): `prod` = `est` * `gain`, 32-bit unsigned.
  - `gain` is sampled at S4 input, with no qualification by valid.
- S5 (quantise): `scaled` = `prod` >> 14, truncated.
  - If `scaled` ≥ 65536: address = all ones and the lane's clip flag is set.
  - Otherwise: address = `scaled[15:16-ADDR_WIDTH]`.
- The `mag_*` registers load only when the S5 valid bit is 1. Otherwise they hold their last value.
- `clip_cnt`:
  - Adds the number of clip flags, 0, 1 or 2, among valid S5 lanes each cycle.
  - Saturates at 0xFFFF. It never wraps, and a +2 from 0xFFFE gives 0xFFFF.
  - When `clip_cnt_clr` is 1, the counter becomes 0 and that cycle's increments are discarded. Clear wins.
- Reset values: all stage registers = 0, `mag_odd` = `mag_even` = 0, `dout_valid` = 0, `clip_cnt` = 0.
- Reset asserted mid-stream clears everything immediately. The first valid output after release appears 5 cycles after the first post-reset `din_valid`.

## Timing
- Latency: 5 clocks from `din_*` and `din_valid` to `mag_*` and `dout_valid`.
  - Input sampled at edge N gives output visible after edge N+5.
- Throughput: 2 samples per clock, sustained indefinitely.
- `dout_valid` is exactly `din_valid` delayed by 5 clocks. It is high in the same cycle the new addresses appear.
- Lane alignment: `mag_odd` and `mag_even` always belong to the same input pair.
  - The downstream row builds its i-delay chain from this ordering, so the lanes must never be swapped.
- A `gain` change at edge N affects data that is in S3 at edge N. It is first visible at the output after edge N+2.
- `clip_cnt` updates one clock after the corresponding S5 output, i.e. 6 clocks after input.
- `clip_cnt_clr` takes effect on the next edge.

## Test plan
- Nominal:
  - Stimulus: `din_odd` = {3000, 4000}, `din_even` = {-4000, -3000}, `gain` = 0x4000, `ADDR_WIDTH` = 10.
  - Required: `est` = 5125 on both lanes; `mag_odd` = `mag_even` = 80 after 5 clocks; `dout_valid` high for 1 clock.
- Abs boundary:
  - Stimulus: I = -32768, Q = 0, `gain` = 0x4000.
  - Required: address 511.
  - Same sample with `gain` = 0x8000: address 1023, `clip_cnt` unchanged (`scaled` = 65534).
- Clip:
  - Stimulus: both lanes I = Q = 32767 (`est` = 45053), `gain` = 0x8000.
  - Required: both addresses 1023; `clip_cnt` increments by 2 per valid cycle.
  - Preload the counter to 0xFFFE: it stops at 0xFFFF.
- Clear priority:
  - Stimulus: assert `clip_cnt_clr` in the same cycle as a double clip.
  - Required: `clip_cnt` = 0 next cycle, then +2 per following clipping cycle.
- Valid bubbles:
  - Stimulus: `din_valid` pattern 1,0,0,1 with distinct magnitudes.
  - Required: `dout_valid` shows the same pattern 5 clocks later; `mag_*` hold the first result through the gap; lane pairing is preserved.
- Reset mid-stream:
  - Stimulus: assert `rst_n` low asynchronously (between edges) while 3 valid pairs are in flight.
  - Required: `mag_*`, `dout_valid` and `clip_cnt` go to 0 immediately; no stale output after release; the first new result appears exactly 5 clocks after the first new `din_valid`.
